// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction buffer between fetch and decode, with a one-cycle redirect flush.
// Latency: a packet accepted at edge N is visible on d_* right after edge N; no fetch-to-decode bypass.
// Backpressure: f_ready drops when full or once a page fault is held (until flush); never depends on d_ready.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_valid,
  output logic                       f_ready,
  input  logic [31:0]                f_inst,
  input  logic [63:0]                f_pc,
  input  logic                       f_page_fault,
  input  logic [4:0]                 f_cause,
  input  logic [63:0]                f_tval,
  input  logic                       flush,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_inst,
  output logic [63:0]                d_pc,
  output logic                       d_page_fault,
  output logic [4:0]                 d_cause,
  output logic [63:0]                d_tval,
  output logic [$clog2(DEPTH):0]     d_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        page_fault;
    logic [4:0]  cause;
    logic [63:0] tval;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fault_hold;
  logic            push;
  logic            pop;

  // Handshake qualification; flush swallows both sides of the cycle.
  always_comb begin
    f_ready = (count != CW'(DEPTH)) && !fault_hold;
    d_valid = (count != '0);
    push    = f_valid && f_ready && !flush;
    pop     = d_valid && d_ready && !flush;
  end

  // Pack the incoming fetch packet into a storage entry.
  always_comb begin
    wr_entry.inst       = f_inst;
    wr_entry.pc         = f_pc;
    wr_entry.page_fault = f_page_fault;
    wr_entry.cause      = f_cause;
    wr_entry.tval       = f_tval;
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and fault hold; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fault_hold <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fault_hold <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (f_page_fault) begin
          fault_hold <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation; data forced to zero while empty.
  always_comb begin
    head         = mem[rd_ptr];
    d_inst       = d_valid ? head.inst       : '0;
    d_pc         = d_valid ? head.pc         : '0;
    d_page_fault = d_valid ? head.page_fault : 1'b0;
    d_cause      = d_valid ? head.cause      : '0;
    d_tval       = d_valid ? head.tval       : '0;
    d_count      = count;
  end

endmodule
